// File: rtl/gsa_ctrl_if.sv
// gsa_ctrl_if: config, sample, averager and result-FIFO signals
// bundled for the growing-sum-average sequencer.
interface gsa_ctrl_if #(
  parameter int N    = 16,
  parameter int NA_W = 8
);
  logic [NA_W-1:0]   cfg_n_avgs_in;
  logic              cfg_start;
  logic              cfg_stop;
  logic              s_valid;
  logic signed [N-1:0] s_data;
  logic              s_ready;
  logic              gsa_valid;
  logic signed [N-1:0] gsa_x;
  logic [NA_W-1:0]   gsa_n_avgs;
  logic              gsa_clr;
  logic              gsa_new_dat;
  logic signed [N-1:0] gsa_y;
  logic              m_valid;
  logic              m_ready;
  logic signed [N-1:0] m_data;
  logic [NA_W-1:0]   m_n_avgs;
  logic              busy;
  logic              overrun;
  logic              cfg_err;

  modport slave (
    input  cfg_n_avgs_in, cfg_start, cfg_stop,
    input  s_valid, s_data,
    output s_ready,
    output gsa_valid, gsa_x, gsa_n_avgs, gsa_clr,
    input  gsa_new_dat, gsa_y,
    output m_valid, m_data, m_n_avgs,
    input  m_ready,
    output busy, overrun, cfg_err
  );

  modport master (
    output cfg_n_avgs_in, cfg_start, cfg_stop,
    output s_valid, s_data,
    input  s_ready,
    input  gsa_valid, gsa_x, gsa_n_avgs, gsa_clr,
    output gsa_new_dat, gsa_y,
    input  m_valid, m_data, m_n_avgs,
    output m_ready,
    input  busy, overrun, cfg_err
  );
endinterface

// File: rtl/gsa_ctrl.sv
// gsa_ctrl: block sequencer for the growing-sum averager; gates
// samples, holds block length, buffers results in a 2-deep FIFO.
module gsa_ctrl #(
  parameter int N        = 16,
  parameter int NA_W     = 8,
  parameter int MAX_LOG2 = 7
) (
  input logic       clk,
  input logic       rst_n,
  gsa_ctrl_if.slave bus
);
  localparam int CW = MAX_LOG2 + 1;
  localparam int EW = N + NA_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_SETTLE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [NA_W-1:0] r_n_avgs;
  logic [NA_W-1:0] w_req;
  logic            w_req_lo;
  logic            w_req_hi;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_last;
  logic [CW-1:0]   r_outst;
  logic            w_run;
  logic            w_acc;
  logic            w_blk_end;
  logic            w_stop;
  logic            w_res;
  logic            r_gsa_valid;
  logic [N-1:0]    r_gsa_x;
  logic            r_overrun;
  logic            r_cfg_err;

  logic [EW-1:0]   r_mem [2];
  logic            r_rd;
  logic            r_wr;
  logic [1:0]      r_fcnt;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic            w_mvalid;
  logic [EW-1:0]   w_head;

  // Requested length clamped into [1, MAX_LOG2]
  assign w_req_lo = (bus.cfg_n_avgs_in == '0);
  assign w_req_hi = (bus.cfg_n_avgs_in > NA_W'(MAX_LOG2));

  always_comb begin
    w_req = bus.cfg_n_avgs_in;
    if (w_req_lo) w_req = NA_W'(1);
    else if (w_req_hi) w_req = NA_W'(MAX_LOG2);
  end

  assign w_stop    = bus.cfg_stop;
  assign w_run     = (r_state == S_RUN);
  assign w_acc     = bus.s_valid & w_run;
  assign w_last    = (CW'(1) << r_n_avgs) - CW'(1);
  assign w_blk_end = w_acc & (r_cnt == w_last);
  assign w_res     = bus.gsa_new_dat & (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (bus.cfg_start) w_next = S_ARM;
      S_ARM:    w_next = S_RUN;
      S_RUN:    if (w_blk_end && (w_req != r_n_avgs))
                  w_next = S_SETTLE;
      S_SETTLE: if (r_outst == '0) w_next = S_ARM;
      default:  w_next = S_IDLE;
    endcase
    if (w_stop) w_next = S_IDLE;
  end

  // Sample counter, in-flight result count, active length
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_outst  <= '0;
      r_n_avgs <= NA_W'(1);
    end else if (w_stop) begin
      r_cnt    <= '0;
      r_outst  <= '0;
    end else begin
      if (r_state == S_ARM) begin
        r_n_avgs <= w_req;
        r_cnt    <= '0;
      end else if (w_acc) begin
        r_cnt <= w_blk_end ? '0 : r_cnt + CW'(1);
      end
      case ({w_blk_end, w_res})
        2'b10:   if (r_outst != '1) r_outst <= r_outst + CW'(1);
        2'b01:   if (r_outst != '0) r_outst <= r_outst - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gsa_valid <= 1'b0;
      r_gsa_x     <= '0;
    end else begin
      r_gsa_valid <= w_acc & ~w_stop;
      r_gsa_x     <= (w_acc & ~w_stop) ? bus.s_data : '0;
    end
  end

  assign w_mvalid = (r_fcnt != 2'd0);
  assign w_full   = (r_fcnt == 2'd2);
  assign w_pop    = w_mvalid & bus.m_ready;
  assign w_push   = w_res & ~w_stop & (~w_full | w_pop);
  assign w_drop   = w_res & ~w_stop & w_full & ~w_pop;
  assign w_head   = r_mem[r_rd];

  // When full, push and pop hit the same slot: read is old, write lands next
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_fcnt   <= 2'd0;
    end else if (w_stop) begin
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_fcnt   <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= {bus.gsa_y, r_n_avgs};
        r_wr        <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
      case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + 2'd1;
        2'b01:   r_fcnt <= r_fcnt - 2'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      if (bus.cfg_start) begin
        r_overrun <= 1'b0;
        r_cfg_err <= 1'b0;
      end
      if ((r_state == S_ARM) && (w_req_lo || w_req_hi))
        r_cfg_err <= 1'b1;
      if (w_drop) r_overrun <= 1'b1;
    end
  end

  assign bus.s_ready    = w_run;
  assign bus.gsa_valid  = r_gsa_valid;
  assign bus.gsa_x      = r_gsa_x;
  assign bus.gsa_n_avgs = r_n_avgs;
  assign bus.gsa_clr    = (r_state == S_ARM);
  assign bus.m_valid    = w_mvalid;
  assign bus.m_data     = w_mvalid ? w_head[EW-1:NA_W] : '0;
  assign bus.m_n_avgs   = w_mvalid ? w_head[NA_W-1:0] : '0;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.overrun    = r_overrun;
  assign bus.cfg_err    = r_cfg_err;
endmodule

// File: tb/tb_gsa_ctrl.sv
// tb_gsa_ctrl: scenario tasks for gsa_ctrl; a result scoreboard
// is filled when strobes are driven and drained at the FIFO port.
module tb_gsa_ctrl;
  localparam int N    = 16;
  localparam int NA_W = 8;

  typedef struct packed {
    logic [N-1:0]    d;
    logic [NA_W-1:0] n;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  gsa_ctrl_if #(.N(N), .NA_W(NA_W)) bus ();

  gsa_ctrl #(.N(N), .NA_W(NA_W), .MAX_LOG2(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  res_t q[$];
  res_t mon_exp;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_pop = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [NA_W-1:0] n);
    bus.cfg_n_avgs_in = n;
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.cfg_stop = 1'b1;
    tick();
    bus.cfg_stop = 1'b0;
  endtask

  task automatic send(input logic [N-1:0] d);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    tick();
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
  endtask

  task automatic strobe(input logic [N-1:0] y);
    bus.gsa_new_dat = 1'b1;
    bus.gsa_y       = y;
    tick();
    bus.gsa_new_dat = 1'b0;
    bus.gsa_y       = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_vec++; if (bus.s_ready !== 1'b0) begin n_err++; $display("FAIL rst_s_ready: got %b want 0", bus.s_ready); end
    n_vec++; if (bus.gsa_valid !== 1'b0) begin n_err++; $display("FAIL rst_gsa_valid: got %b want 0", bus.gsa_valid); end
    n_vec++; if (bus.gsa_n_avgs !== 8'd1) begin n_err++; $display("FAIL rst_n_avgs: got %0d want 1", bus.gsa_n_avgs); end
    n_vec++; if (bus.gsa_clr !== 1'b0) begin n_err++; $display("FAIL rst_clr: got %b want 0", bus.gsa_clr); end
    n_vec++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL rst_m_valid: got %b want 0", bus.m_valid); end
    n_vec++; if (bus.m_data !== 16'd0) begin n_err++; $display("FAIL rst_m_data: got %h want 0", bus.m_data); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    n_vec++; if ({bus.overrun, bus.cfg_err} !== 2'b00) begin n_err++; $display("FAIL rst_flags: got %b%b want 00", bus.overrun, bus.cfg_err); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    pulse_start(8'd1);
    n_vec++; if (bus.gsa_clr !== 1'b1) begin n_err++; $display("FAIL basic_clr: got %b want 1", bus.gsa_clr); end
    n_vec++; if (bus.s_ready !== 1'b0) begin n_err++; $display("FAIL basic_arm_rdy: got %b want 0", bus.s_ready); end
    tick();
    n_vec++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL basic_run_rdy: got %b want 1", bus.s_ready); end
    n_vec++; if (bus.gsa_n_avgs !== 8'd1) begin n_err++; $display("FAIL basic_n: got %0d want 1", bus.gsa_n_avgs); end
    send(16'd0);
    n_vec++; if ({bus.gsa_valid, bus.gsa_x} !== {1'b1, 16'd0}) begin n_err++; $display("FAIL basic_x0: got %b/%h want 1/0000", bus.gsa_valid, bus.gsa_x); end
    send(16'd10);
    n_vec++; if (bus.gsa_x !== 16'd10) begin n_err++; $display("FAIL basic_x1: got %h want 000a", bus.gsa_x); end
    n_vec++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL basic_stay_run: got %b want 1", bus.s_ready); end
    q.push_back({16'd5, 8'd1});
    strobe(16'd5);
    n_vec++; if ({bus.m_valid, bus.m_data, bus.m_n_avgs} !== {1'b1, 16'd5, 8'd1}) begin n_err++; $display("FAIL basic_mlat: got %b/%h/%0d want 1/0005/1", bus.m_valid, bus.m_data, bus.m_n_avgs); end
    n_vec++; if ({bus.gsa_valid, bus.gsa_x} !== {1'b0, 16'd0}) begin n_err++; $display("FAIL basic_xidle: got %b/%h want 0/0000", bus.gsa_valid, bus.gsa_x); end
    send(16'd20);
    send(16'd20);
    q.push_back({16'd15, 8'd1});
    strobe(16'd15);
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    n_vec++; if (q.size() != 0) begin n_err++; $display("FAIL basic_drain: %0d pending want 0", q.size()); end
    n_vec++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL basic_ovr: got %b want 0", bus.overrun); end
    pulse_stop();
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL basic_stop: got %b want 0", bus.busy); end
  endtask

  task automatic test_len_change();
    pulse_start(8'd2);
    tick();
    send(16'd1);
    send(16'd2);
    bus.cfg_n_avgs_in = 8'd3;
    send(16'd3);
    n_vec++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL len_mid_rdy: got %b want 1", bus.s_ready); end
    send(16'd4);
    n_vec++; if (bus.s_ready !== 1'b0) begin n_err++; $display("FAIL len_settle_rdy: got %b want 0", bus.s_ready); end
    tick();
    tick();
    n_vec++; if ({bus.s_ready, bus.gsa_n_avgs} !== {1'b0, 8'd2}) begin n_err++; $display("FAIL len_hold: got %b/%0d want 0/2", bus.s_ready, bus.gsa_n_avgs); end
    q.push_back({16'h1234, 8'd2});
    strobe(16'h1234);
    n_vec++; if ({bus.s_ready, bus.gsa_clr} !== 2'b00) begin n_err++; $display("FAIL len_exit: got %b%b want 00", bus.s_ready, bus.gsa_clr); end
    tick();
    n_vec++; if (bus.gsa_clr !== 1'b1) begin n_err++; $display("FAIL len_clr: got %b want 1", bus.gsa_clr); end
    tick();
    n_vec++; if ({bus.s_ready, bus.gsa_n_avgs} !== {1'b1, 8'd3}) begin n_err++; $display("FAIL len_new: got %b/%0d want 1/3", bus.s_ready, bus.gsa_n_avgs); end
    bus.cfg_n_avgs_in = 8'd2;
    for (int k = 0; k < 7; k++) send(16'(k));
    n_vec++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL len_7th: got %b want 1", bus.s_ready); end
    send(16'd7);
    n_vec++; if (bus.s_ready !== 1'b0) begin n_err++; $display("FAIL len_8th: got %b want 0", bus.s_ready); end
    q.push_back({16'h0abc, 8'd3});
    strobe(16'h0abc);
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    n_vec++; if (q.size() != 0) begin n_err++; $display("FAIL len_drain: %0d pending want 0", q.size()); end
    pulse_stop();
  endtask

  task automatic test_clamp();
    pulse_start(8'd0);
    tick();
    n_vec++; if ({bus.gsa_n_avgs, bus.cfg_err} !== {8'd1, 1'b1}) begin n_err++; $display("FAIL clamp_lo: got %0d/%b want 1/1", bus.gsa_n_avgs, bus.cfg_err); end
    pulse_stop();
    n_vec++; if (bus.cfg_err !== 1'b1) begin n_err++; $display("FAIL clamp_sticky: got %b want 1", bus.cfg_err); end
    pulse_start(8'd9);
    n_vec++; if (bus.cfg_err !== 1'b0) begin n_err++; $display("FAIL clamp_clear: got %b want 0", bus.cfg_err); end
    tick();
    n_vec++; if ({bus.gsa_n_avgs, bus.cfg_err} !== {8'd7, 1'b1}) begin n_err++; $display("FAIL clamp_hi: got %0d/%b want 7/1", bus.gsa_n_avgs, bus.cfg_err); end
    pulse_stop();
    pulse_start(8'd7);
    tick();
    n_vec++; if ({bus.gsa_n_avgs, bus.cfg_err} !== {8'd7, 1'b0}) begin n_err++; $display("FAIL clamp_max: got %0d/%b want 7/0", bus.gsa_n_avgs, bus.cfg_err); end
    pulse_stop();
  endtask

  task automatic test_backpressure();
    int p0;
    bus.m_ready = 1'b0;
    pulse_start(8'd1);
    tick();
    q.push_back({16'h0111, 8'd1});
    q.push_back({16'h0222, 8'd1});
    strobe(16'h0111);
    n_vec++; if ({bus.m_valid, bus.m_data, bus.overrun} !== {1'b1, 16'h0111, 1'b0}) begin n_err++; $display("FAIL bp_first: got %b/%h/%b want 1/0111/0", bus.m_valid, bus.m_data, bus.overrun); end
    strobe(16'h0222);
    n_vec++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL bp_second: got %b want 0", bus.overrun); end
    strobe(16'h0333);
    n_vec++; if (bus.overrun !== 1'b1) begin n_err++; $display("FAIL bp_ovr: got %b want 1", bus.overrun); end
    repeat (3) tick();
    n_vec++; if ({bus.m_data, bus.m_n_avgs} !== {16'h0111, 8'd1}) begin n_err++; $display("FAIL bp_hold: got %h/%0d want 0111/1", bus.m_data, bus.m_n_avgs); end
    p0 = n_pop;
    bus.m_ready = 1'b1;
    repeat (5) tick();
    n_vec++; if (n_pop - p0 != 2) begin n_err++; $display("FAIL bp_drain: got %0d pops want 2", n_pop - p0); end
    n_vec++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b want 0", bus.m_valid); end
    pulse_start(8'd1);
    n_vec++; if ({bus.overrun, bus.busy} !== 2'b01) begin n_err++; $display("FAIL bp_clr: got %b%b want 01", bus.overrun, bus.busy); end
    pulse_stop();
  endtask

  task automatic test_abort();
    bus.m_ready = 1'b1;
    pulse_start(8'd3);
    tick();
    send(16'd1);
    send(16'd2);
    send(16'd3);
    bus.m_ready = 1'b0;
    strobe(16'h0555);
    n_vec++; if (bus.m_valid !== 1'b1) begin n_err++; $display("FAIL abort_stored: got %b want 1", bus.m_valid); end
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h0099;
    pulse_stop();
    bus.s_valid = 1'b0;
    n_vec++; if ({bus.busy, bus.s_ready, bus.m_valid, bus.gsa_valid} !== 4'b0000) begin n_err++; $display("FAIL abort_idle: got %b%b%b%b want 0000", bus.busy, bus.s_ready, bus.m_valid, bus.gsa_valid); end
    bus.m_ready = 1'b1;
    strobe(16'h0666);
    n_vec++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL abort_late: got %b want 0", bus.m_valid); end
    pulse_start(8'd3);
    tick();
    bus.cfg_n_avgs_in = 8'd2;
    for (int k = 0; k < 7; k++) send(16'(k));
    n_vec++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL abort_cnt7: got %b want 1", bus.s_ready); end
    send(16'd7);
    n_vec++; if (bus.s_ready !== 1'b0) begin n_err++; $display("FAIL abort_cnt8: got %b want 0", bus.s_ready); end
    q.push_back({16'h0777, 8'd3});
    strobe(16'h0777);
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    n_vec++; if (q.size() != 0) begin n_err++; $display("FAIL abort_drain: %0d pending want 0", q.size()); end
    pulse_stop();
  endtask

  task automatic test_async_reset();
    pulse_start(8'd2);
    tick();
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h0042;
    tick();
    n_vec++; if (bus.gsa_valid !== 1'b1) begin n_err++; $display("FAIL ar_pre: got %b want 1", bus.gsa_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if ({bus.s_ready, bus.gsa_valid, bus.busy, bus.gsa_clr} !== 4'b0000) begin n_err++; $display("FAIL ar_ctl: got %b%b%b%b want 0000", bus.s_ready, bus.gsa_valid, bus.busy, bus.gsa_clr); end
    n_vec++; if ({bus.gsa_x, bus.gsa_n_avgs} !== {16'd0, 8'd1}) begin n_err++; $display("FAIL ar_data: got %h/%0d want 0000/1", bus.gsa_x, bus.gsa_n_avgs); end
    bus.s_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL ar_after: got %b want 0", bus.busy); end
  endtask

  initial begin
    bus.cfg_n_avgs_in = '0;
    bus.cfg_start     = 1'b0;
    bus.cfg_stop      = 1'b0;
    bus.s_valid       = 1'b0;
    bus.s_data        = '0;
    bus.gsa_new_dat   = 1'b0;
    bus.gsa_y         = '0;
    bus.m_ready       = 1'b1;
    fork
      forever begin
        @(negedge clk);
        if (rst_n && bus.m_valid && bus.m_ready) begin
          n_vec++;
          n_pop++;
          if (q.size() == 0) begin
            n_err++;
            $display("FAIL fifo_out: got %h/%0d want no result", bus.m_data, bus.m_n_avgs);
          end else begin
            mon_exp = q.pop_front();
            if ({bus.m_data, bus.m_n_avgs} !== mon_exp) begin
              n_err++;
              $display("FAIL fifo_out: got %h/%0d want %h/%0d", bus.m_data, bus.m_n_avgs, mon_exp.d, mon_exp.n);
            end
          end
        end
      end
    join_none
    test_reset();
    test_basic();
    test_len_change();
    test_clamp();
    test_backpressure();
    test_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
